// File: rtl/nio2_sys_irq_aggregator.sv
// Interrupt aggregator: per-source level/edge capture into PENDING, masked by ENABLE, registered irq/irq_id.
// Optional build macro IRQ_AGG_DROP_COUNT_EN adds a saturating counter of edge events lost to an already-pending bit.
module nio2_sys_irq_aggregator #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [2:0]         address,
    input  logic               chipselect,
    input  logic               write_n,
    input  logic [15:0]        writedata,
    output logic [15:0]        readdata,
    output logic               irq,
    output logic [3:0]         irq_id
);

    localparam logic [15:0] VALID_MASK = 16'((32'h1 << NUM_IRQ) - 32'h1);

    logic [15:0] irqIn16;
    logic [15:0] pending_q, pending_d;
    logic [15:0] enable_q, enable_d;
    logic [15:0] edgeSel_q, edgeSel_d;
    logic [15:0] prevIn_q;
    logic [15:0] readdata_q, readdata_d;
    logic        irq_q, irq_d;
    logic [3:0]  irqId_q, irqId_d;

    logic        wrEn;
    logic [15:0] w1cMask;
    logic [15:0] swsetMask;
    logic [15:0] evt;
    logic [15:0] act;
    logic [15:0] dropRead;

    assign irqIn16 = 16'(irq_in);

    always_comb begin
        wrEn      = chipselect & ~write_n;
        w1cMask   = (wrEn && address == 3'd0) ? (writedata & VALID_MASK) : 16'h0000;
        swsetMask = (wrEn && address == 3'd5) ? (writedata & VALID_MASK) : 16'h0000;
        evt       = (edgeSel_q & irqIn16 & ~prevIn_q) | (~edgeSel_q & irqIn16);
        act       = pending_q & enable_q;
    end

    // Set sources are OR-ed in after the clear, so an event or SWSET always beats a W1C.
    always_comb begin
        pending_d = ((pending_q & ~w1cMask) | evt | swsetMask) & VALID_MASK;
        enable_d  = enable_q;
        edgeSel_d = edgeSel_q;
        if (wrEn && address == 3'd1) begin
            enable_d = writedata & VALID_MASK;
        end
        if (wrEn && address == 3'd2) begin
            edgeSel_d = writedata & VALID_MASK;
        end
    end

    always_comb begin
        irq_d   = |act;
        irqId_d = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (act[i]) begin
                irqId_d = i[3:0];
            end
        end
    end

`ifdef IRQ_AGG_DROP_COUNT_EN
    logic [15:0] dropCnt_q, dropCnt_d;
    logic        dropHit;

    // Bits being cleared this cycle do not count: the new event re-arms them instead of being lost.
    always_comb begin
        dropHit   = |(evt & edgeSel_q & pending_q & ~w1cMask);
        dropCnt_d = dropCnt_q;
        if (wrEn && address == 3'd6) begin
            dropCnt_d = 16'h0000;
        end else if (dropHit && dropCnt_q != 16'hFFFF) begin
            dropCnt_d = dropCnt_q + 16'h0001;
        end
        dropRead = dropCnt_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dropCnt_q <= 16'h0000;
        end else begin
            dropCnt_q <= dropCnt_d;
        end
    end
`else
    assign dropRead = 16'h0000;
`endif

    always_comb begin
        readdata_d = 16'h0000;
        case (address)
            3'd0:    readdata_d = pending_q;
            3'd1:    readdata_d = enable_q;
            3'd2:    readdata_d = edgeSel_q;
            3'd3:    readdata_d = {11'b0, irq_q, irqId_q};
            3'd4:    readdata_d = irqIn16;
            3'd6:    readdata_d = dropRead;
            default: readdata_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pending_q  <= 16'h0000;
            enable_q   <= 16'h0000;
            edgeSel_q  <= 16'h0000;
            prevIn_q   <= 16'h0000;
            readdata_q <= 16'h0000;
            irq_q      <= 1'b0;
            irqId_q    <= 4'd0;
        end else begin
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            edgeSel_q  <= edgeSel_d;
            prevIn_q   <= irqIn16;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
            irqId_q    <= irqId_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;
    assign irq_id   = irqId_q;

endmodule
